// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback,
// holds the NZCV flag register and applies conditional execution.
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] alu_flags,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_source,
    output logic [1:0] alu_control,
    output logic [3:0] flags,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cmd;
    logic       is_cmp_c;
    logic       cond_ok_c;
    logic [1:0] alu_op_c;
    logic       flag_we_c;
    logic       pc_write_c;
    logic       ir_write_c;
    logic       mem_write_c;
    logic       reg_write_c;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;

    assign cmd      = funct[4:1];
    assign is_cmp_c = (cmd == CMD_CMP);
    assign {flag_n, flag_z, flag_c, flag_v} = flags;

    // State register; unused encodings fall back to FETCH via next-state logic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NZCV register, loaded on leaving an execute state when S is set or on CMP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (flag_we_c) begin
            flags <= alu_flags;
        end
    end

    // Condition check against the stored flags
    always_comb begin
        cond_ok_c = 1'b0;
        case (cond)
            4'b0000: cond_ok_c = flag_z;
            4'b0001: cond_ok_c = !flag_z;
            4'b0010: cond_ok_c = flag_c;
            4'b0011: cond_ok_c = !flag_c;
            4'b0100: cond_ok_c = flag_n;
            4'b0101: cond_ok_c = !flag_n;
            4'b0110: cond_ok_c = flag_v;
            4'b0111: cond_ok_c = !flag_v;
            4'b1010: cond_ok_c = (flag_n == flag_v);
            4'b1011: cond_ok_c = (flag_n != flag_v);
            4'b1110: cond_ok_c = 1'b1;
            default: cond_ok_c = 1'b0;
        endcase
    end

    // ALU operation from cmd; unknown commands execute as ADD
    always_comb begin
        alu_op_c = 2'b00;
        case (cmd)
            CMD_ADD: alu_op_c = 2'b00;
            CMD_SUB: alu_op_c = 2'b01;
            CMD_AND: alu_op_c = 2'b10;
            CMD_ORR: alu_op_c = 2'b11;
            CMD_CMP: alu_op_c = 2'b01;
            default: alu_op_c = 2'b00;
        endcase
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d     = S_FETCH;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        flag_we_c   = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = 2'b00;
        imm_source  = (op == 2'b11) ? 2'b00 : op;

        case (state_q)
            S_FETCH: begin
                ir_write_c = 1'b1;
                pc_write_c = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (!cond_ok_c || op == 2'b11) begin
                    state_d = S_FETCH;
                end else if (op == 2'b01) begin
                    state_d = S_MEMADR;
                end else if (op == 2'b00) begin
                    state_d = funct[5] ? S_EXEC_I : S_EXEC_R;
                end else begin
                    state_d = S_BRANCH;
                end
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                state_d   = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
            end
            S_MEMWR: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_b   = (state_q == S_EXEC_I) ? 2'b01 : 2'b00;
                alu_control = alu_op_c;
                flag_we_c   = funct[0] || is_cmp_c;
                state_d     = is_cmp_c ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write_c = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are suppressed for the whole time reset is held
    assign pc_write  = pc_write_c  & rst_n;
    assign ir_write  = ir_write_c  & rst_n;
    assign mem_write = mem_write_c & rst_n;
    assign reg_write = reg_write_c & rst_n;
    assign state     = STATE_W'(state_q);

endmodule
